// File: rtl/signed_iterative_divider_rounded_saturated.sv
// Sequential restoring divider: 38-bit signed dividend / 18-bit signed divisor -> saturated 20-bit quotient + remainder.
// Optional build macro DIV_ROUND_NEAREST_EN: round quotient to nearest (ties away from zero) before saturation.
`timescale 1ns/1ps
module signed_iterative_divider_rounded_saturated #(
  parameter int DIVIDEND_W = 38,
  parameter int DIVISOR_W  = 18,
  parameter int QUOT_W     = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic signed [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOT_W-1:0]     quotient,
  output logic signed [DIVISOR_W-1:0]  remainder,
  output logic                         overflow,
  output logic                         div_by_zero
);

  // state | meaning
  // IDLE  | in_ready=1, waiting for operands
  // BUSY  | one restoring step per cycle, MSB first
  // FIX   | apply signs, rounding, saturation; register results
  // DONE  | out_valid=1, results held until out_ready

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W:0] POS_LIM = (DIVIDEND_W+1)'((64'd1 << (QUOT_W-1)) - 64'd1);
  localparam logic [DIVIDEND_W:0] NEG_LIM = (DIVIDEND_W+1)'(64'd1 << (QUOT_W-1));
  localparam logic signed [QUOT_W-1:0] Q_MAX = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic signed [QUOT_W-1:0] Q_MIN = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd_q;   // dividend magnitude shifts out, quotient bits shift in
  logic [DIVISOR_W-1:0]  dsr_mag;
  logic [DIVISOR_W-1:0]  rem;
  logic                  sign_a;
  logic                  sign_b;
  logic                  dsr_zero;
  logic [CNT_W-1:0]      cnt;

  logic [DIVIDEND_W-1:0] a_mag;
  logic [DIVISOR_W-1:0]  b_mag;
  logic [DIVISOR_W:0]    rem_shift;
  logic [DIVISOR_W:0]    rem_diff;
  logic                  step_ge;

  always_comb begin
    a_mag     = dividend[DIVIDEND_W-1] ? DIVIDEND_W'(-dividend) : DIVIDEND_W'(dividend);
    b_mag     = divisor[DIVISOR_W-1] ? DIVISOR_W'(-divisor) : DIVISOR_W'(divisor);
    rem_shift = {rem, dvd_q[DIVIDEND_W-1]};
    // rem < |divisor| keeps the difference inside a signed DIVISOR_W+1 range, so its MSB is the borrow
    rem_diff  = rem_shift - {1'b0, dsr_mag};
    step_ge   = ~rem_diff[DIVISOR_W];
  end

  logic                        q_neg;
  logic [DIVIDEND_W:0]         q_mag_rnd;
  logic signed [QUOT_W-1:0]    q_fix;
  logic signed [DIVISOR_W-1:0] rem_fix;
  logic                        ovf_fix;

  always_comb begin
    q_neg = sign_a ^ sign_b;
`ifdef DIV_ROUND_NEAREST_EN
    q_mag_rnd = {1'b0, dvd_q} + (DIVIDEND_W+1)'({rem, 1'b0} >= {1'b0, dsr_mag});
`else
    q_mag_rnd = {1'b0, dvd_q};
`endif
    rem_fix = sign_a ? $signed(-rem) : $signed(rem);
    ovf_fix = 1'b0;
    q_fix   = '0;
    if (dsr_zero) begin
      q_fix   = sign_a ? Q_MIN : Q_MAX;
      rem_fix = '0;
    end else if (q_neg) begin
      if (q_mag_rnd > NEG_LIM) begin
        q_fix   = Q_MIN;
        ovf_fix = 1'b1;
      end else begin
        q_fix = -$signed(q_mag_rnd[QUOT_W-1:0]);
      end
    end else begin
      if (q_mag_rnd > POS_LIM) begin
        q_fix   = Q_MAX;
        ovf_fix = 1'b1;
      end else begin
        q_fix = $signed(q_mag_rnd[QUOT_W-1:0]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      dvd_q       <= '0;
      dsr_mag     <= '0;
      rem         <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      dsr_zero    <= 1'b0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_q    <= a_mag;
            dsr_mag  <= b_mag;
            sign_a   <= dividend[DIVIDEND_W-1];
            sign_b   <= divisor[DIVISOR_W-1];
            dsr_zero <= (divisor == '0);
            rem      <= '0;
            cnt      <= CNT_W'(DIVIDEND_W-1);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          dvd_q <= {dvd_q[DIVIDEND_W-2:0], step_ge};
          rem   <= step_ge ? rem_diff[DIVISOR_W-1:0] : rem_shift[DIVISOR_W-1:0];
          cnt   <= cnt - CNT_W'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          quotient    <= q_fix;
          remainder   <= rem_fix;
          overflow    <= ovf_fix;
          div_by_zero <= dsr_zero;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_iterative_divider_rounded_saturated.sv
// Scoreboard bench for the signed iterative divider: directed corner cases, random operands,
// back-pressure and mid-operation reset, checked against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_signed_iterative_divider_rounded_saturated;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [37:0] dividend;
  logic signed [17:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [19:0] quotient;
  logic signed [17:0] remainder;
  logic               overflow;
  logic               div_by_zero;

  signed_iterative_divider_rounded_saturated dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint a;
    longint b;
    longint q;
    longint r;
    longint ovf;
    longint dbz;
    longint t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_ready = 1'b0;

  function automatic exp_t model(longint a, longint b);
    exp_t   e;
    longint q;
    longint r;
    e.a = a; e.b = b; e.t = 0; e.ovf = 0; e.dbz = 0;
    if (b == 0) begin
      e.q = (a >= 0) ? 524287 : -524288;
      e.r = 0;
      e.dbz = 1;
      return e;
    end
    q = a / b;
    r = a % b;
`ifdef DIV_ROUND_NEAREST_EN
    if (2 * (r < 0 ? -r : r) >= (b < 0 ? -b : b))
      q = ((a < 0) != (b < 0)) ? q - 1 : q + 1;
`endif
    if (q > 524287) begin
      q = 524287; e.ovf = 1;
    end else if (q < -524288) begin
      q = -524288; e.ovf = 1;
    end
    e.q = q;
    e.r = r;
    return e;
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(longint a, longint b);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    dividend = 38'(a);
    divisor  = 18'(b);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready stuck at 0 for %0d/%0d", a, b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e = model(a, b);
    e.t = longint'($time);
    sb.push_back(e);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL result_timeout: %0d results outstanding", sb.size());
      sb.delete();
    end
  endtask

  // monitor: latency on the rising edge of out_valid, result on each handshake
  initial begin
    bit   prev_valid = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (out_valid && !prev_valid) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_valid: out_valid=1 with nothing outstanding");
          end else begin
            check("latency_edges", (longint'($time) - sb[0].t - 5) / 10, 39);
          end
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_result: q=%0d with nothing outstanding", quotient);
          end else begin
            e = sb.pop_front();
            check($sformatf("quotient %0d/%0d", e.a, e.b), quotient, e.q);
            check($sformatf("remainder %0d/%0d", e.a, e.b), remainder, e.r);
            check($sformatf("overflow %0d/%0d", e.a, e.b), overflow, e.ovf);
            check($sformatf("div_by_zero %0d/%0d", e.a, e.b), div_by_zero, e.dbz);
          end
        end
      end
      prev_valid = out_valid && reset;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  longint dir_a[] = '{100, -100, 45, -45, 64'sd137438953471, -64'sd137438953472, -524288, -5,
                      0, 524287, 524288, -524289, 64'sd137438953471, -64'sd137438953472, 7, 131071};
  longint dir_b[] = '{7, 7, -6, 6, 1, -1, 1, 0,
                      5, 1, -1, 1, -131072, 131071, 0, -131072};

  initial begin
    logic signed [37:0] ra;
    logic signed [17:0] rb;
    longint a, b;
    exp_t   e;
    int     n;

    reset = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_overflow", overflow, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    @(posedge clk); #1 reset = 1'b1;

    foreach (dir_a[i]) begin
      issue(dir_a[i], dir_b[i]);
      wait_done();
    end

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ra = 38'({$urandom(), $urandom()});
      rb = 18'($urandom());
      case ($urandom_range(0, 3))
        0: a = ra;
        1: a = longint'($urandom_range(0, 4000000)) - 2000000;
        2: a = longint'($urandom_range(0, 200)) - 100;
        default: a = ra >>> $urandom_range(0, 30);
      endcase
      case ($urandom_range(0, 9))
        0: b = 0;
        1, 2, 3: b = longint'($urandom_range(1, 20)) * (($urandom_range(0, 1) != 0) ? -1 : 1);
        default: b = rb;
      endcase
      issue(a, b);
      wait_done();
    end
    rand_ready = 1'b0;

    // back-pressure: result held while a new operand waits
    @(posedge clk); #1 out_ready = 1'b0;
    e = model(-1000, 3);
    issue(-1000, 3);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_rise", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 38'sd7; divisor = 18'sd2;
    repeat (10) begin
      @(negedge clk);
      check("bp_quotient", quotient, e.q);
      check("bp_remainder", remainder, e.r);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    repeat (5) begin
      @(negedge clk);
      check("bp_no_extra_op", out_valid, 0);
    end
    check("bp_scoreboard_empty", sb.size(), 0);

    // reset asserted on the 20th BUSY cycle
    issue(100, 7);
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_div_by_zero", div_by_zero, 0);
    issue(100, 7);
    wait_done();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
